cla_word_adder_seq: RTL and testbench

Multi-byte add/subtract sequencer that sits directly upstream of the team's 8-bit carry-lookahead adder slice (`eightbit_cla_adder`, ports `a`, `b`, `cin`, `s`, `cout`). It accepts a wide operand pair over a valid/ready handshake and feeds the single 8-bit slice one byte per cycle, LSB first, chaining the carry through a register. It returns the full-width sum, carry-out and signed overflow over a second valid/ready handshake. This trades latency for area: one 8-bit slice serves any word width.

---
 rtl/cla_word_adder_seq.sv | 172 +++++++++++++++++
 tb/tb_cla_word_adder_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_word_adder_seq
// Brief    : Multi-byte add/subtract sequencer that feeds one 8-bit CLA slice
//            a byte per cycle, LSB first, with a registered carry chain.
// Revision : 1.0 - initial release
// ============================================================================

module eightbit_cla_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    logic       w_acc;
    logic       w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is expanded as a flat sum of generate/propagate products.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_pp   = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            w_acc = w_g[i];
            w_pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & w_g[j]);
                w_pp  = w_pp & w_p[j];
            end
            w_c[i+1] = w_acc | (w_pp & cin);
        end
    end

    assign s    = w_p ^ w_c[7:0];
    assign cout = w_c[8];

endmodule

module cla_word_adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int c_W     = 8 * NBYTES;
    localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic [c_W-1:0]       r_sum;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic                 r_cout;
    logic                 r_ovf;
    logic [7:0]           w_a_byte;
    logic [7:0]           w_b_byte;
    logic [7:0]           w_s;
    logic                 w_cout;

    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_a_byte = r_a[8*k +: 8];
                w_b_byte = r_b[8*k +: 8];
            end
        end
    end

    eightbit_cla_adder u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)        w_next = S_RUN;
            S_RUN:   if (r_idx == c_LAST) w_next = S_DONE;
            S_DONE:  if (out_ready)       w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // B is stored already inverted for subtract so RUN is a plain add chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (r_idx == c_IDX_W'(k)) begin
                            r_sum[8*k +: 8] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST) begin
                        r_cout <= w_cout;
                        r_ovf  <= (r_a[c_W-1] == r_b[c_W-1]) && (w_s[7] != r_a[c_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_word_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_word_adder_seq
// Brief    : Scoreboard bench for cla_word_adder_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cla_word_adder_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef logic [W+1:0] res_t;   // {ovf, cout, sum}

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    res_t exp_q[$];
    int   acc_q[$];
    logic bp_hold  = 1'b0;
    logic rand_bp  = 1'b0;

    cla_word_adder_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W:0] full;
        longint     sx, sy, sr;
        logic       co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            full = {1'b0, x} - {1'b0, y};
            co   = (x >= y);
            sr   = sx - sy;
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            co   = full[W];
            sr   = sx + sy + longint'(ci);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, full[W-1:0]};
    endfunction

    // Consumer: out_ready is changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bp_hold)      out_ready = 1'b0;
        else if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
        else              out_ready = 1'b1;
    end

    // Monitor: samples on the falling edge, between input changes and the next active edge.
    logic presented = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t e;
        int   t;
        if (rst) begin
            presented = 1'b0;
        end else if (out_valid) begin
            if (!presented) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {31'd0, ovf, cout, sum}, 64'd0 - 1);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("sum",     64'(sum),  64'(e[W-1:0]));
                    check("cout",    64'(cout), 64'(e[W]));
                    check("ovf",     64'(ovf),  64'(e[W+1]));
                    check("latency", 64'(cyc - t), 64'(NBYTES));
                end
                held      = {ovf, cout, sum};
                presented = 1'b1;
            end else begin
                check("hold_stable", 64'({ovf, cout, sum}), 64'(held));
            end
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) presented = 1'b0;
        end else begin
            presented = 1'b0;
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        int w;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back(model(x, y, ci, s));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed add / subtract cases
        issue(32'h0000_000F, 32'h0000_0010, 1'b0, 1'b0);
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'h0000_0025, 32'h0000_001F, 1'b1, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        issue(32'h0000_0025, 32'h0000_001F, 1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        drain();

        // Backpressure with ignored in_valid pulses while DONE
        bp_hold = 1'b1;
        issue(32'h1234_0000, 32'h0000_4321, 1'b0, 1'b0);
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); sub = 1'b0; cin = 1'b0;
            in_valid = (i % 2 == 0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        bp_hold  = 1'b0;
        issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b1);
        drain();

        // Reset during RUN at byte index 2
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        #1;
        check("rst_run_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_sum",       64'(sum),       64'd0);
        check("post_rst_in_ready",  64'(in_ready),  64'd1);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drain();

        // Randomized traffic with random consumer stalls
        rand_bp = 1'b1;
        repeat (40) begin
            issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_bp = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
